// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes,
// framing FSM state encoding and a counter-width helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Bits needed to hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy flags; the head word is
// readable combinationally so the consumer can pop and use it on one edge.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = cnt_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  assign w_push = wr_en && !r_full;
  assign w_pop  = rd_en && !r_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == DEPTH_C);
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = r_full;
  assign empty   = r_empty;
  assign count   = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO absorbs pushed words and a framing FSM
// serialises them back-to-back with optional parity and 1 or 2 stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          clr_overflow,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          serial,
  output logic                          active,
  output logic                          done
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(DATA_BITS);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam bit   HAS_PARITY = (PARITY_MODE != PARITY_NONE);
  localparam logic PARITY_INV = (PARITY_MODE == PARITY_ODD);

  tx_state_t            r_state;
  tx_state_t            w_state_next;
  logic [CW-1:0]        r_clk_cnt;
  logic [CW-1:0]        w_clk_cnt_next;
  logic [BW-1:0]        r_bit_idx;
  logic [BW-1:0]        w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 r_parity;
  logic                 w_parity_next;
  logic                 r_serial;
  logic                 w_serial_next;
  logic                 r_active;
  logic                 r_done;
  logic                 w_done_next;
  logic                 r_overflow;
  logic                 w_pop;
  logic                 w_bit_end;
  logic [DATA_BITS-1:0] w_fifo_data;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_fifo_data),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (count)
  );

  assign w_bit_end = (r_clk_cnt == CLK_LAST);

  always_comb begin
    w_state_next   = r_state;
    w_clk_cnt_next = r_clk_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_parity_next  = r_parity;
    w_serial_next  = r_serial;
    w_done_next    = 1'b0;
    w_pop          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_serial_next = 1'b1;
        if (!w_fifo_empty) begin
          w_pop          = 1'b1;
          w_state_next   = ST_START;
          w_clk_cnt_next = '0;
          w_bit_idx_next = '0;
          w_shift_next   = w_fifo_data;
          w_parity_next  = (^w_fifo_data) ^ PARITY_INV;
          w_serial_next  = 1'b0;
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_state_next   = ST_DATA;
          w_clk_cnt_next = '0;
          w_bit_idx_next = '0;
          w_serial_next  = r_shift[0];
          w_shift_next   = r_shift >> 1;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          if (r_bit_idx == DATA_LAST) begin
            w_bit_idx_next = '0;
            if (HAS_PARITY) begin
              w_state_next  = ST_PARITY;
              w_serial_next = r_parity;
            end else begin
              w_state_next  = ST_STOP;
              w_serial_next = 1'b1;
            end
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
            w_serial_next  = r_shift[0];
            w_shift_next   = r_shift >> 1;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end

      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_next   = ST_STOP;
          w_clk_cnt_next = '0;
          w_bit_idx_next = '0;
          w_serial_next  = 1'b1;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end

      ST_STOP: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          if (r_bit_idx == STOP_LAST) begin
            w_done_next    = 1'b1;
            w_bit_idx_next = '0;
            // Queued data chains straight into the next start bit.
            if (!w_fifo_empty) begin
              w_pop         = 1'b1;
              w_state_next  = ST_START;
              w_shift_next  = w_fifo_data;
              w_parity_next = (^w_fifo_data) ^ PARITY_INV;
              w_serial_next = 1'b0;
            end else begin
              w_state_next  = ST_IDLE;
              w_serial_next = 1'b1;
            end
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end

      default: begin
        w_state_next  = ST_IDLE;
        w_serial_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_serial   <= 1'b1;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_parity  <= w_parity_next;
      r_serial  <= w_serial_next;
      r_active  <= (w_state_next != ST_IDLE);
      r_done    <= w_done_next;
      // A dropped push outranks a simultaneous clear.
      if (wr_en && w_fifo_full) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign full     = w_fifo_full;
  assign empty    = w_fifo_empty;
  assign overflow = r_overflow;
  assign serial   = r_serial;
  assign active   = r_active;
  assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Three differently configured transmitters share one stimulus stream and are
// checked every cycle against a frame-level queue model.
module tb_uart_tx_fifo;

  localparam int NI = 3;
  localparam int A_DB = 8,  A_CPB = 4, A_DEPTH = 8, A_PAR = 1, A_STOP = 1;
  localparam int B_DB = 8,  B_CPB = 3, B_DEPTH = 4, B_PAR = 2, B_STOP = 2;
  localparam int C_DB = 16, C_CPB = 1, C_DEPTH = 2, C_PAR = 0, C_STOP = 1;
  localparam int P_DB    [NI] = '{A_DB, B_DB, C_DB};
  localparam int P_CPB   [NI] = '{A_CPB, B_CPB, C_CPB};
  localparam int P_DEPTH [NI] = '{A_DEPTH, B_DEPTH, C_DEPTH};
  localparam int P_PAR   [NI] = '{A_PAR, B_PAR, C_PAR};
  localparam int P_STOP  [NI] = '{A_STOP, B_STOP, C_STOP};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        clr_overflow = 1'b0;
  logic [7:0]  wr_data8 = '0;
  logic [15:0] wr_data16 = '0;

  logic       full_a, empty_a, ovf_a, serial_a, active_a, done_a;
  logic       full_b, empty_b, ovf_b, serial_b, active_b, done_b;
  logic       full_c, empty_c, ovf_c, serial_c, active_c, done_c;
  logic [3:0] count_a;
  logic [2:0] count_b;
  logic [1:0] count_c;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(A_DB), .CLKS_PER_BIT(A_CPB), .FIFO_DEPTH(A_DEPTH),
                 .PARITY_MODE(A_PAR), .STOP_BITS(A_STOP)) u_dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data8), .clr_overflow(clr_overflow),
    .full(full_a), .empty(empty_a), .count(count_a), .overflow(ovf_a),
    .serial(serial_a), .active(active_a), .done(done_a));

  uart_tx_fifo #(.DATA_BITS(B_DB), .CLKS_PER_BIT(B_CPB), .FIFO_DEPTH(B_DEPTH),
                 .PARITY_MODE(B_PAR), .STOP_BITS(B_STOP)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data8), .clr_overflow(clr_overflow),
    .full(full_b), .empty(empty_b), .count(count_b), .overflow(ovf_b),
    .serial(serial_b), .active(active_b), .done(done_b));

  uart_tx_fifo #(.DATA_BITS(C_DB), .CLKS_PER_BIT(C_CPB), .FIFO_DEPTH(C_DEPTH),
                 .PARITY_MODE(C_PAR), .STOP_BITS(C_STOP)) u_dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data16), .clr_overflow(clr_overflow),
    .full(full_c), .empty(empty_c), .count(count_c), .overflow(ovf_c),
    .serial(serial_c), .active(active_c), .done(done_c));

  logic       dut_serial [NI];
  logic       dut_active [NI];
  logic       dut_done   [NI];
  logic       dut_full   [NI];
  logic       dut_empty  [NI];
  logic       dut_ovf    [NI];
  logic [7:0] dut_count  [NI];

  assign dut_serial[0] = serial_a; assign dut_serial[1] = serial_b; assign dut_serial[2] = serial_c;
  assign dut_active[0] = active_a; assign dut_active[1] = active_b; assign dut_active[2] = active_c;
  assign dut_done[0]   = done_a;   assign dut_done[1]   = done_b;   assign dut_done[2]   = done_c;
  assign dut_full[0]   = full_a;   assign dut_full[1]   = full_b;   assign dut_full[2]   = full_c;
  assign dut_empty[0]  = empty_a;  assign dut_empty[1]  = empty_b;  assign dut_empty[2]  = empty_c;
  assign dut_ovf[0]    = ovf_a;    assign dut_ovf[1]    = ovf_b;    assign dut_ovf[2]    = ovf_c;
  assign dut_count[0]  = 8'(count_a);
  assign dut_count[1]  = 8'(count_b);
  assign dut_count[2]  = 8'(count_c);

  // Reference model: a word queue per instance plus the current frame as a
  // bit vector and the cycle position within it (-1 when idle).
  int          qbuf  [NI][16];
  int          qhead [NI];
  int          qsize [NI];
  int          pos   [NI];
  int          flen  [NI];
  logic [31:0] frame [NI];
  bit          m_ovf [NI];
  bit          m_done[NI];
  int          done_seen [NI];

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cycle, got, exp);
    end
  endtask

  task automatic load_frame(input int k, input int data);
    logic [31:0] f;
    int nb;
    int ones;
    f = '0;
    nb = 1;
    ones = 0;
    for (int i = 0; i < P_DB[k]; i++) begin
      f[nb] = 1'((data >> i) & 1);
      ones += (data >> i) & 1;
      nb++;
    end
    if (P_PAR[k] != 0) begin
      f[nb] = 1'(ones % 2) ^ (P_PAR[k] == 2);
      nb++;
    end
    for (int i = 0; i < P_STOP[k]; i++) begin
      f[nb] = 1'b1;
      nb++;
    end
    frame[k] = f;
    flen[k]  = nb * P_CPB[k];
    pos[k]   = 0;
  endtask

  task automatic model_edge(input int k, input bit r, input bit we, input int data, input bit clr);
    int sz;
    if (!r) begin
      qhead[k] = 0; qsize[k] = 0; pos[k] = -1; m_ovf[k] = 0; m_done[k] = 0;
    end else begin
      sz = qsize[k];
      m_done[k] = 0;
      if (pos[k] >= 0) begin
        if (pos[k] == flen[k] - 1) begin
          m_done[k] = 1;
          pos[k] = -1;
        end else begin
          pos[k]++;
        end
      end
      if (pos[k] < 0 && sz > 0) begin
        load_frame(k, qbuf[k][qhead[k]]);
        qhead[k] = (qhead[k] + 1) % 16;
        qsize[k]--;
      end
      if (we) begin
        if (sz == P_DEPTH[k]) begin
          m_ovf[k] = 1;
        end else begin
          qbuf[k][(qhead[k] + qsize[k]) % 16] = data;
          qsize[k]++;
        end
      end
      if (clr && !(we && sz == P_DEPTH[k])) m_ovf[k] = 0;
    end
  endtask

  task automatic compare_all();
    logic exp_serial;
    for (int k = 0; k < NI; k++) begin
      exp_serial = (pos[k] < 0) ? 1'b1 : frame[k][pos[k] / P_CPB[k]];
      check_value($sformatf("serial%0d", k), 64'(dut_serial[k]), 64'(exp_serial));
      check_value($sformatf("active%0d", k), 64'(dut_active[k]), 64'(pos[k] >= 0));
      check_value($sformatf("done%0d", k),   64'(dut_done[k]),   64'(m_done[k]));
      check_value($sformatf("count%0d", k),  64'(dut_count[k]),  64'(qsize[k]));
      check_value($sformatf("empty%0d", k),  64'(dut_empty[k]),  64'(qsize[k] == 0));
      check_value($sformatf("full%0d", k),   64'(dut_full[k]),   64'(qsize[k] == P_DEPTH[k]));
      check_value($sformatf("ovf%0d", k),    64'(dut_ovf[k]),    64'(m_ovf[k]));
      if (dut_done[k] === 1'b1) done_seen[k]++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cycle++;
    model_edge(0, rst, wr_en, int'(wr_data8), clr_overflow);
    model_edge(1, rst, wr_en, int'(wr_data8), clr_overflow);
    model_edge(2, rst, wr_en, int'(wr_data16), clr_overflow);
    if (wr_en) $display("cycle %0d push ab=0x%02h c=0x%04h", cycle, wr_data8, wr_data16);
    #1;
    compare_all();
  endtask

  task automatic push_word(input logic [7:0] d8, input logic [15:0] d16);
    wr_en = 1'b1;
    wr_data8 = d8;
    wr_data16 = d16;
    step();
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_done_seen();
    for (int k = 0; k < NI; k++) done_seen[k] = 0;
  endtask

  logic [63:0] vec_a, exp_a, vec_c;
  logic [10:0] pat_a;
  int rate;

  initial begin
    for (int k = 0; k < NI; k++) begin
      qhead[k] = 0; qsize[k] = 0; pos[k] = -1; flen[k] = 1;
      frame[k] = '0; m_ovf[k] = 0; m_done[k] = 0; done_seen[k] = 0;
    end

    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);

    // Single frame: 0xA5 on A/B, 0x8001 on the 16-bit instance.
    clear_done_seen();
    push_word(8'hA5, 16'h8001);
    vec_a = '0;
    vec_c = '0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (i < 44) vec_a[i] = serial_a;
      if (i < 18) vec_c[i] = serial_c;
    end
    pat_a = 11'h54A;  // start, 1,0,1,0,0,1,0,1, even parity 0, stop
    exp_a = '0;
    for (int i = 0; i < 44; i++) exp_a[i] = pat_a[i / 4];
    check_value("a5_waveform", vec_a, exp_a);
    check_value("w8001_waveform", vec_c, 64'h30002);
    check_value("single_done_a", 64'(done_seen[0]), 64'd1);
    check_value("single_done_b", 64'(done_seen[1]), 64'd1);
    check_value("single_done_c", 64'(done_seen[2]), 64'd1);

    // Back-to-back frames.
    clear_done_seen();
    push_word(8'h01, 16'h0001);
    push_word(8'h02, 16'h0002);
    push_word(8'h03, 16'h0003);
    idle(160);
    check_value("b2b_done_a", 64'(done_seen[0]), 64'd3);
    check_value("b2b_done_b", 64'(done_seen[1]), 64'd3);
    check_value("b2b_done_c", 64'(done_seen[2]), 64'd3);

    // Overflow burst of 10 words, then clear.
    clear_done_seen();
    for (int i = 0; i < 10; i++) push_word(8'(i + 16), 16'(i * 257));
    check_value("burst_ovf_a", 64'(ovf_a), 64'd1);
    idle(1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check_value("clr_ovf_a", 64'(ovf_a), 64'd0);
    idle(420);
    check_value("burst_frames_a", 64'(done_seen[0]), 64'd9);
    check_value("burst_frames_b", 64'(done_seen[1]), 64'd5);
    check_value("burst_frames_c", 64'(done_seen[2]), 64'd3);

    // Reset during data bit 3 of A with words still queued.
    clear_done_seen();
    for (int i = 0; i < 4; i++) push_word(8'(8'hC0 + i), 16'(16'hF000 + i));
    idle(15);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_value("rst_serial_a", 64'(serial_a), 64'd1);
    check_value("rst_active_a", 64'(active_a), 64'd0);
    check_value("rst_count_a", 64'(count_a), 64'd0);
    check_value("rst_empty_a", 64'(empty_a), 64'd1);
    idle(200);
    check_value("rst_no_done_a", 64'(done_seen[0]), 64'd0);
    check_value("rst_no_done_b", 64'(done_seen[1]), 64'd0);
    check_value("rst_no_done_c", 64'(done_seen[2]), 64'd0);

    // Randomised traffic with varying push density and rare resets.
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0) rate = (i / 250) % 3 == 0 ? 5 : ((i / 250) % 3 == 1 ? 30 : 90);
      wr_en = ($urandom_range(0, 99) < rate);
      wr_data8 = 8'($urandom);
      wr_data16 = 16'($urandom);
      clr_overflow = ($urandom_range(0, 31) == 0);
      rst = !($urandom_range(0, 599) == 0);
      step();
    end
    wr_en = 1'b0;
    clr_overflow = 1'b0;
    rst = 1'b1;
    idle(500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
